// File: rtl/aes128_pkg.sv
// Shared AES-128 definitions: FSM encodings, round constants, S-boxes and GF(2^8) multipliers.
package aes128_pkg;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE     = 3'd0;
   localparam state_t ST_KEYGEN   = 3'd1;
   localparam state_t ST_INIT_ARK = 3'd2;
   localparam state_t ST_ROUND    = 3'd3;
   localparam state_t ST_FINAL    = 3'd4;

   // Table byte 0 sits in the top bits, so entry b lives at bit offset 8*(255-b) = {~b, 3'b000}.
   localparam logic [2047:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

   localparam logic [2047:0] INV_SBOX = {
      128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
      128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
      128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
      128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
      128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
      128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
      128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
      128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d};

   function automatic logic [7:0] sbox(input logic [7:0] b);
      return SBOX[{~b, 3'b000} +: 8];
   endfunction

   function automatic logic [7:0] inv_sbox(input logic [7:0] b);
      return INV_SBOX[{~b, 3'b000} +: 8];
   endfunction

   function automatic logic [7:0] rcon(input logic [3:0] idx);
      case (idx)
         4'd1:    return 8'h01;
         4'd2:    return 8'h02;
         4'd3:    return 8'h04;
         4'd4:    return 8'h08;
         4'd5:    return 8'h10;
         4'd6:    return 8'h20;
         4'd7:    return 8'h40;
         4'd8:    return 8'h80;
         4'd9:    return 8'h1b;
         4'd10:   return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

   function automatic logic [7:0] gf_mul2(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul9(input logic [7:0] b);
      return gf_mul2(gf_mul2(gf_mul2(b))) ^ b;
   endfunction

   function automatic logic [7:0] gf_mul11(input logic [7:0] b);
      return gf_mul2(gf_mul2(gf_mul2(b))) ^ gf_mul2(b) ^ b;
   endfunction

   function automatic logic [7:0] gf_mul13(input logic [7:0] b);
      return gf_mul2(gf_mul2(gf_mul2(b))) ^ gf_mul2(gf_mul2(b)) ^ b;
   endfunction

   function automatic logic [7:0] gf_mul14(input logic [7:0] b);
      return gf_mul2(gf_mul2(gf_mul2(b))) ^ gf_mul2(gf_mul2(b)) ^ gf_mul2(b);
   endfunction

endpackage

// File: rtl/aes128_decrypt_top_level_inv_sub_bytes_shift_rows_alt.sv
// Combinational InvShiftRows followed by InvSubBytes on a column-major 128-bit state.
module inv_sub_bytes_shift_rows_alt
   import aes128_pkg::*;
(
   input  logic [127:0] data_i,
   output logic [127:0] data_o
);

   // Byte (row r, column c) takes the byte from column (c - r) mod 4 of the same row.
   always_comb begin
      data_o = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            data_o[127 - 8*(4*c + r) -: 8] = inv_sbox(data_i[127 - 8*(4*((c - r + 4) % 4) + r) -: 8]);
         end
      end
   end

endmodule

// File: rtl/aes128_decrypt_top_level.sv
// Iterative AES-128 inverse cipher: expands the key into an 11-entry store, then runs one round per clock.
module aes128_decrypt_top_level
   import aes128_pkg::*;
#(
   parameter int REUSE_KEYS = 0
)
(
   input  logic         pi_clk,
   input  logic         pi_rst,
   input  logic [127:0] pi_input_key,
   input  logic [127:0] pi_input_data,
   input  logic         pi_start,
   output logic         po_busy,
   output logic         po_end_of_decryption,
   output logic [127:0] po_out
);

   state_t         state_q, state_d;
   logic [3:0]     rnd_q, rnd_d;
   logic [127:0]   data_q, data_d;
   logic [127:0]   out_q, out_d;
   logic           done_q, done_d;
   logic           valid_q, valid_d;
   logic [127:0]   rk_q [0:10];
   logic           rk_we;
   logic [3:0]     rk_idx;
   logic [127:0]   rk_wdata;
   logic [127:0]   isr_out;
   logic           key_hit;

   function automatic logic [127:0] key_expand(input logic [127:0] k, input logic [7:0] rc);
      logic [31:0] t;
      logic [127:0] n;
      t = {sbox(k[23:16]), sbox(k[15:8]), sbox(k[7:0]), sbox(k[31:24])} ^ {rc, 24'h000000};
      n[127:96] = k[127:96] ^ t;
      n[95:64]  = k[95:64]  ^ n[127:96];
      n[63:32]  = k[63:32]  ^ n[95:64];
      n[31:0]   = k[31:0]   ^ n[63:32];
      return n;
   endfunction

   function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
      logic [127:0] r;
      logic [7:0] a0, a1, a2, a3;
      r = '0;
      for (int c = 0; c < 4; c++) begin
         a0 = s[127 - 32*c -: 8];
         a1 = s[119 - 32*c -: 8];
         a2 = s[111 - 32*c -: 8];
         a3 = s[103 - 32*c -: 8];
         r[127 - 32*c -: 8] = gf_mul14(a0) ^ gf_mul11(a1) ^ gf_mul13(a2) ^ gf_mul9(a3);
         r[119 - 32*c -: 8] = gf_mul9(a0)  ^ gf_mul14(a1) ^ gf_mul11(a2) ^ gf_mul13(a3);
         r[111 - 32*c -: 8] = gf_mul13(a0) ^ gf_mul9(a1)  ^ gf_mul14(a2) ^ gf_mul11(a3);
         r[103 - 32*c -: 8] = gf_mul11(a0) ^ gf_mul13(a1) ^ gf_mul9(a2)  ^ gf_mul14(a3);
      end
      return r;
   endfunction

   inv_sub_bytes_shift_rows_alt u_isr (
      .data_i (data_q),
      .data_o (isr_out)
   );

   assign key_hit = (REUSE_KEYS != 0) && valid_q && (pi_input_key == rk_q[0]);

   always_ff @(posedge pi_clk or posedge pi_rst) begin
      if (pi_rst) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_ff @(posedge pi_clk or posedge pi_rst) begin
      if (pi_rst) begin
         rnd_q   <= '0;
         data_q  <= '0;
         out_q   <= '0;
         done_q  <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         rnd_q   <= rnd_d;
         data_q  <= data_d;
         out_q   <= out_d;
         done_q  <= done_d;
         valid_q <= valid_d;
      end
   end

   // Round-key contents are don't-care after reset, so the store carries no reset.
   always_ff @(posedge pi_clk) begin
      if (rk_we) rk_q[rk_idx] <= rk_wdata;
   end

   always_comb begin
      state_d  = state_q;
      rnd_d    = rnd_q;
      data_d   = data_q;
      out_d    = out_q;
      done_d   = 1'b0;
      valid_d  = valid_q;
      rk_we    = 1'b0;
      rk_idx   = 4'd0;
      rk_wdata = pi_input_key;
      case (state_q)
         ST_IDLE: begin
            if (pi_start) begin
               data_d = pi_input_data;
               rnd_d  = 4'd1;
               rk_we  = 1'b1;
               if (key_hit) begin
                  state_d = ST_INIT_ARK;
               end else begin
                  state_d = ST_KEYGEN;
                  valid_d = 1'b0;
               end
            end
         end
         ST_KEYGEN: begin
            rk_we    = 1'b1;
            rk_idx   = rnd_q;
            rk_wdata = key_expand(rk_q[rnd_q - 4'd1], rcon(rnd_q));
            if (rnd_q == 4'd10) begin
               valid_d = 1'b1;
               state_d = ST_INIT_ARK;
            end else begin
               rnd_d = rnd_q + 4'd1;
            end
         end
         ST_INIT_ARK: begin
            data_d  = data_q ^ rk_q[10];
            rnd_d   = 4'd9;
            state_d = ST_ROUND;
         end
         ST_ROUND: begin
            data_d = inv_mix_columns(isr_out ^ rk_q[rnd_q]);
            rnd_d  = rnd_q - 4'd1;
            if (rnd_q == 4'd1) state_d = ST_FINAL;
         end
         ST_FINAL: begin
            out_d   = isr_out ^ rk_q[0];
            done_d  = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      po_busy              = (state_q != ST_IDLE);
      po_end_of_decryption = done_q;
      po_out               = out_q;
   end

endmodule
